// File: rtl/sram10t_word_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram10t_word_ctrl
//  Description : Word-level front end for the bit-wide, dual-read SRAM10T_16B
//                macro. A whole-word write is issued as DW single-bit write
//                cycles. A whole-word read is issued as DW/2 cycles that use
//                both read ports, so two bits come back per cycle. Each
//                command ends with a one-cycle response carrying the word.
//  Ports       :
//    clk          clock; all state changes on the rising edge
//    rst          asynchronous, active-high reset
//    cmd_valid    command request
//    cmd_ready    high only while idle; accept = cmd_valid & cmd_ready
//    cmd_wr       1 = write word, 0 = read word
//    cmd_data     write data; bit i is stored at SRAM address i
//    rsp_valid    one-cycle response pulse (no backpressure)
//    rsp_data     read: fetched word; write: echo of the written word
//    sram_addr1   SRAM addr1 (write address / read port 1 address)
//    sram_addr2   SRAM addr2 (read port 2 address)
//    sram_wline   SRAM writeLine
//    sram_rdwr    SRAM RdWr (1 = write)
//    sram_deven   SRAM DevEn (active low)
//    sram_rline1  SRAM readLine1
//    sram_rline2  SRAM readLine2
//  Revision    : 1.0  initial release
// ============================================================================
module sram10t_word_ctrl #(
    parameter  int AW = 4,
    localparam int DW = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] sram_addr1,
    output logic [AW-1:0] sram_addr2,
    output logic          sram_wline,
    output logic          sram_rdwr,
    output logic          sram_deven,
    input  logic          sram_rline1,
    input  logic          sram_rline2
);

    // Last bit index of a write and last pair index of a read.
    localparam logic [AW-1:0] c_last_bit  = AW'(DW - 1);
    localparam logic [AW-1:0] c_last_pair = AW'(DW / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_WFLUSH = 3'd2,
        S_READ   = 3'd3,
        S_RDRAIN = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;    // bit index while writing, pair index while reading
    logic [DW-1:0] r_word;   // write data, or read bits as they arrive

    logic [AW-1:0] w_cnt_inc;
    logic [DW-1:0] w_word_shifted;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Read data arrives one cycle after its address is latched, so pair 0
    // lands one cycle late. Shifting each new pair in at the top means that
    // after DW/2 captures every pair sits at its own bit position.
    assign w_word_shifted = {sram_rline2, sram_rline1, r_word[DW-1:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_word     <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            sram_addr1 <= '0;
            sram_addr2 <= '0;
            sram_wline <= 1'b0;
            sram_rdwr  <= 1'b0;
            sram_deven <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_word     <= cmd_data;
                        r_cnt      <= '0;
                        cmd_ready  <= 1'b0;
                        sram_deven <= 1'b0;
                        sram_addr1 <= '0;
                        if (cmd_wr) begin
                            // First write cycle is presented straight away.
                            r_state    <= S_WRITE;
                            sram_rdwr  <= 1'b1;
                            sram_wline <= cmd_data[0];
                            sram_addr2 <= '0;
                        end else begin
                            r_state    <= S_READ;
                            sram_rdwr  <= 1'b0;
                            sram_wline <= 1'b0;
                            sram_addr2 <= AW'(1);
                        end
                    end
                end

                S_WRITE: begin
                    if (r_cnt == c_last_bit) begin
                        // Keep the last bit on the bus for one more edge.
                        r_state <= S_WFLUSH;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        sram_addr1 <= w_cnt_inc;
                        sram_wline <= r_word[w_cnt_inc];
                    end
                end

                S_WFLUSH: begin
                    r_state    <= S_RESP;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= r_word;
                    sram_deven <= 1'b1;
                    sram_rdwr  <= 1'b0;
                    sram_wline <= 1'b0;
                    sram_addr1 <= '0;
                    sram_addr2 <= '0;
                end

                S_READ: begin
                    // Data on the read lines belongs to the previous pair.
                    if (r_cnt != '0) begin
                        r_word <= w_word_shifted;
                    end
                    if (r_cnt == c_last_pair) begin
                        // Addresses held so the final pair is returned.
                        r_state <= S_RDRAIN;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        sram_addr1 <= {w_cnt_inc[AW-2:0], 1'b0};
                        sram_addr2 <= {w_cnt_inc[AW-2:0], 1'b1};
                    end
                end

                S_RDRAIN: begin
                    r_state    <= S_RESP;
                    r_word     <= w_word_shifted;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= w_word_shifted;
                    sram_deven <= 1'b1;
                    sram_rdwr  <= 1'b0;
                    sram_addr1 <= '0;
                    sram_addr2 <= '0;
                end

                S_RESP: begin
                    // Ready only rises here, so no accept can happen in RESP.
                    r_state   <= S_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    r_state    <= S_IDLE;
                    cmd_ready  <= 1'b1;
                    sram_deven <= 1'b1;
                    sram_rdwr  <= 1'b0;
                    sram_wline <= 1'b0;
                    sram_addr1 <= '0;
                    sram_addr2 <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
